// File: rtl/ram_rw_slave_pkg.sv
// ram_rw_slave_pkg: shared constants, size codes, FSM states and helpers for ram_rw_slave
//   PC_START       default byte address of SRAM word 0
//   SIZE_B..SIZE_D access size codes carried on ram_rw_size
//   rws_state_e    responder FSM states
//   align_mask     address low bits that must be zero for a given size
//   bit_mask       byte write-enable mask expanded to a per-bit mask
package ram_rw_slave_pkg;
  localparam logic [63:0] PC_START = 64'h8000_0000;
  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;
  typedef enum logic [2:0] {
    RWS_IDLE   = 3'd0,
    RWS_WAIT   = 3'd1,
    RWS_ACCESS = 3'd2,
    RWS_CAPT   = 3'd3,
    RWS_DONE   = 3'd4
  } rws_state_e;
  function automatic logic [2:0] align_mask(input logic [2:0] size);
    return size == SIZE_B ? 3'b000 :
           size == SIZE_H ? 3'b001 :
           size == SIZE_W ? 3'b011 : 3'b111;
  endfunction
  function automatic logic [63:0] bit_mask(input logic [7:0] wmask);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{wmask[i]}};
    return m;
  endfunction
endpackage

// File: rtl/ram_rw_slave_if.sv
// ram_rw_slave_if: core-side ram_rw request/response bundle
//   master modport: drives cen/wen/addr/wdata/wmask/size, sees ready/data/err
//   slave modport : the responder view (ram_rw_slave)
interface ram_rw_slave_if;
  logic        ram_rw_cen;
  logic        ram_rw_wen;
  logic [63:0] ram_rw_addr;
  logic [63:0] ram_rw_wdata;
  logic [7:0]  ram_rw_wmask;
  logic [2:0]  ram_rw_size;
  logic        ram_rw_ready;
  logic [63:0] ram_rw_data;
  logic        ram_rw_err;
  modport master (
    output ram_rw_cen, ram_rw_wen, ram_rw_addr, ram_rw_wdata, ram_rw_wmask, ram_rw_size,
    input  ram_rw_ready, ram_rw_data, ram_rw_err
  );
  modport slave (
    input  ram_rw_cen, ram_rw_wen, ram_rw_addr, ram_rw_wdata, ram_rw_wmask, ram_rw_size,
    output ram_rw_ready, ram_rw_data, ram_rw_err
  );
endinterface

// File: rtl/ram_rw_addr_chk.sv
// ram_rw_addr_chk: combinational range/alignment check and SRAM word index computation
//   addr_i  byte address of the request
//   size_i  access size code
//   fault_o out-of-range, illegal size or misaligned access
//   idx_o   word index (addr - ADDR_BASE) >> 3, meaningful only when fault_o is low
module ram_rw_addr_chk
  import ram_rw_slave_pkg::*;
#(
  parameter logic [63:0] ADDR_BASE  = PC_START,
  parameter int          DEPTH_LOG2 = 16
) (
  input  logic [63:0]           addr_i,
  input  logic [2:0]            size_i,
  output logic                  fault_o,
  output logic [DEPTH_LOG2-1:0] idx_o
);
  localparam logic [63:0] SPAN = 64'd8 << DEPTH_LOG2;
  logic [63:0] off;
  // full 64-bit offset so the upper-bound compare sees addresses far past the SRAM
  assign off = addr_i - ADDR_BASE;
  assign fault_o = (addr_i < ADDR_BASE) || (off >= SPAN) || (size_i > SIZE_D) ||
                   (|(addr_i[2:0] & align_mask(size_i)));
  assign idx_o = off[DEPTH_LOG2+2:3];
endmodule

// File: rtl/ram_rw_slave.sv
// ram_rw_slave: memory-side responder translating one ram_rw request at a time into a
//   word access on a synchronous single-port SRAM with 1-cycle read latency.
//   clk, rst_n     single rising-edge clock, asynchronous active-low reset
//   ram_rw         slave modport: cen/wen/addr/wdata/wmask/size in; ready/data/err out
//   sram_en_o      one-cycle enable in the ACCESS state
//   sram_wen_o     write enable (qualified by sram_en_o)
//   sram_idx_o     word index of the latched request
//   sram_wdata_o   latched write data
//   sram_bwmask_o  latched byte mask expanded to bits
//   sram_rdata_i   read data, valid the cycle after sram_en_o
module ram_rw_slave
  import ram_rw_slave_pkg::*;
#(
  parameter logic [63:0] ADDR_BASE  = PC_START,
  parameter int          DEPTH_LOG2 = 16,
  parameter int          LATENCY    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_rw_slave_if.slave         ram_rw,
  output logic                  sram_en_o,
  output logic                  sram_wen_o,
  output logic [DEPTH_LOG2-1:0] sram_idx_o,
  output logic [63:0]           sram_wdata_o,
  output logic [63:0]           sram_bwmask_o,
  input  logic [63:0]           sram_rdata_i
);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY == 0 ? 0 : LATENCY - 1);
  rws_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wen_q, wen_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [7:0]            wmask_q, wmask_d;
  logic [63:0]           data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  chk_fault;
  logic [DEPTH_LOG2-1:0] chk_idx;
  ram_rw_addr_chk #(.ADDR_BASE(ADDR_BASE), .DEPTH_LOG2(DEPTH_LOG2)) u_chk (
    .addr_i (ram_rw.ram_rw_addr),
    .size_i (ram_rw.ram_rw_size),
    .fault_o(chk_fault),
    .idx_o  (chk_idx)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    data_d  = data_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RWS_IDLE: if (ram_rw.ram_rw_cen) begin
        wen_d   = ram_rw.ram_rw_wen;
        idx_d   = chk_idx;
        wdata_d = ram_rw.ram_rw_wdata;
        wmask_d = ram_rw.ram_rw_wmask;
        cnt_d   = LAT_M1;
        state_d = chk_fault ? RWS_DONE : (LATENCY == 0 ? RWS_ACCESS : RWS_WAIT);
        // a fault completes straight away with cleared data
        ready_d = chk_fault;
        err_d   = chk_fault;
        data_d  = chk_fault ? '0 : data_q;
      end
      RWS_WAIT: begin
        state_d = cnt_q == 4'd0 ? RWS_ACCESS : RWS_WAIT;
        cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
      end
      RWS_ACCESS: state_d = RWS_CAPT;
      RWS_CAPT: begin
        data_d  = wen_q ? data_q : sram_rdata_i;
        ready_d = 1'b1;
        state_d = RWS_DONE;
      end
      default: state_d = RWS_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RWS_IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end
  // enable is a pure state decode so reset removes it without waiting for a clock
  assign sram_en_o           = state_q == RWS_ACCESS;
  assign sram_wen_o          = sram_en_o & wen_q;
  assign sram_idx_o          = idx_q;
  assign sram_wdata_o        = wdata_q;
  assign sram_bwmask_o       = bit_mask(wmask_q);
  assign ram_rw.ram_rw_ready = ready_q;
  assign ram_rw.ram_rw_err   = err_q;
  assign ram_rw.ram_rw_data  = data_q;
endmodule

// File: tb/tb_ram_rw_slave.sv
// tb_ram_rw_slave: bench for ram_rw_slave with LATENCY=0 and LATENCY=3 instances
module tb_ram_rw_slave;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SPAN = 64'h8_0000;
  typedef struct {
    logic        sel;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [2:0]  size;
  } req_t;
  typedef struct {
    req_t        r;
    logic        err;
    int          lat;
    logic [63:0] data;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        sel = 1'b0, cen = 1'b0, wen = 1'b0;
  logic [63:0] addr = '0, wdata = '0;
  logic [7:0]  wmask = '0;
  logic [2:0]  size = '0;
  ram_rw_slave_if if0 ();
  ram_rw_slave_if if1 ();
  assign if0.ram_rw_cen = cen & ~sel;
  assign if1.ram_rw_cen = cen & sel;
  assign if0.ram_rw_wen = wen;
  assign if1.ram_rw_wen = wen;
  assign if0.ram_rw_addr = addr;
  assign if1.ram_rw_addr = addr;
  assign if0.ram_rw_wdata = wdata;
  assign if1.ram_rw_wdata = wdata;
  assign if0.ram_rw_wmask = wmask;
  assign if1.ram_rw_wmask = wmask;
  assign if0.ram_rw_size = size;
  assign if1.ram_rw_size = size;
  logic        en0, wen0, en1, wen1;
  logic [15:0] idx0, idx1;
  logic [63:0] wd0, wd1, bw0, bw1, rd0 = '0, rd1 = '0;
  ram_rw_slave #(.LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ram_rw(if0.slave),
    .sram_en_o(en0), .sram_wen_o(wen0), .sram_idx_o(idx0),
    .sram_wdata_o(wd0), .sram_bwmask_o(bw0), .sram_rdata_i(rd0)
  );
  ram_rw_slave #(.LATENCY(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .ram_rw(if1.slave),
    .sram_en_o(en1), .sram_wen_o(wen1), .sram_idx_o(idx1),
    .sram_wdata_o(wd1), .sram_bwmask_o(bw1), .sram_rdata_i(rd1)
  );
  // SRAM models below each DUT, plus access monitors
  bit [63:0]   mem0 [0:65535];
  bit [63:0]   mem1 [0:65535];
  int          en_cnt0 = 0, en_cnt1 = 0;
  logic [15:0] acc_idx0 = '0, acc_idx1 = '0;
  logic [63:0] acc_bw0 = '0, acc_bw1 = '0, acc_wd0 = '0, acc_wd1 = '0;
  logic        acc_wen0 = 1'b0, acc_wen1 = 1'b0;
  always @(posedge clk) begin
    if (en0) begin
      if (wen0) mem0[idx0] <= (mem0[idx0] & ~bw0) | (wd0 & bw0);
      else rd0 <= mem0[idx0];
      en_cnt0 <= en_cnt0 + 1;
      acc_idx0 <= idx0;
      acc_bw0 <= bw0;
      acc_wd0 <= wd0;
      acc_wen0 <= wen0;
    end
    if (en1) begin
      if (wen1) mem1[idx1] <= (mem1[idx1] & ~bw1) | (wd1 & bw1);
      else rd1 <= mem1[idx1];
      en_cnt1 <= en_cnt1 + 1;
      acc_idx1 <= idx1;
      acc_bw1 <= bw1;
      acc_wd1 <= wd1;
      acc_wen1 <= wen1;
    end
  end
  logic        rdy, err;
  logic [63:0] data;
  assign rdy  = sel ? if1.ram_rw_ready : if0.ram_rw_ready;
  assign err  = sel ? if1.ram_rw_err : if0.ram_rw_err;
  assign data = sel ? if1.ram_rw_data : if0.ram_rw_data;
  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // reference model: word store per DUT and the last data_o each DUT should show
  bit [63:0]   ref_mem [int];
  logic [63:0] last_data [2];
  function automatic bit ref_fault(input req_t r);
    return r.addr < BASE || r.addr - BASE >= SPAN || r.size > 3 ||
           (r.addr % (64'd1 << r.size)) != 0;
  endfunction
  function automatic int ref_key(input req_t r);
    return int'((r.addr - BASE) / 8) + (r.sel ? 65536 : 0);
  endfunction
  function automatic logic [63:0] ref_word(input req_t r);
    int k = ref_key(r);
    return ref_mem.exists(k) ? ref_mem[k] : 64'd0;
  endfunction
  function automatic logic [63:0] byte_bits(input logic [7:0] m);
    logic [63:0] b = '0;
    for (int i = 0; i < 8; i++) if (m[i]) b[8*i +: 8] = 8'hFF;
    return b;
  endfunction
  task automatic ref_expect(input req_t r, output logic e, output int lat, output logic [63:0] d);
    e = ref_fault(r);
    lat = e ? 1 : (r.sel ? 6 : 3);
    d = e ? 64'd0 : (r.wen ? last_data[r.sel] : ref_word(r));
  endtask
  task automatic ref_apply(input req_t r);
    logic [63:0] w;
    if (ref_fault(r)) last_data[r.sel] = 64'd0;
    else if (!r.wen) last_data[r.sel] = ref_word(r);
    else begin
      w = ref_word(r);
      for (int i = 0; i < 8; i++) if (r.wmask[i]) w[8*i +: 8] = r.wdata[8*i +: 8];
      ref_mem[ref_key(r)] = w;
    end
  endtask
  task automatic drive(input req_t r);
    sel = r.sel;
    cen = 1'b1;
    wen = r.wen;
    addr = r.addr;
    wdata = r.wdata;
    wmask = r.wmask;
    size = r.size;
  endtask
  // called in an IDLE cycle; returns in the IDLE cycle after the ready pulse
  task automatic run(input req_t r, input logic exp_err, input int exp_lat,
                     input logic [63:0] exp_data, input bit chain, input req_t nxt);
    int c, en_before;
    logic [63:0] exp_idx;
    drive(r);
    en_before = r.sel ? en_cnt1 : en_cnt0;
    exp_idx = (r.addr - BASE) >> 3;
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!rdy && c < 40);
    chk("ready_seen", rdy, 1);
    chk("latency", c, exp_lat);
    chk("err", err, exp_err);
    chk("data", data, exp_data);
    if (!exp_err) begin
      chk("sram_idx", r.sel ? acc_idx1 : acc_idx0, {48'd0, exp_idx[15:0]});
      chk("sram_bwmask", r.sel ? acc_bw1 : acc_bw0, byte_bits(r.wmask));
      chk("sram_wen", r.sel ? acc_wen1 : acc_wen0, r.wen);
      chk("sram_wdata", r.sel ? acc_wd1 : acc_wd0, r.wdata);
    end
    if (chain) drive(nxt);
    else cen = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_pulse_width", rdy, 0);
    chk("sram_en_count", (r.sel ? en_cnt1 : en_cnt0) - en_before, exp_err ? 0 : 1);
  endtask
  initial begin
    vec_t  tab [19];
    req_t  r, r2;
    logic  e;
    int    lat, seen, en_before;
    logic [63:0] d;
    tab[0]  = '{'{0, 1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 3}, 0, 3, 64'h0};
    tab[1]  = '{'{0, 0, 64'h8000_0008, 64'h0, 8'h00, 3}, 0, 3, 64'h1122_3344_5566_7788};
    tab[2]  = '{'{0, 1, 64'h8000_0008, 64'h0000_0000_00AB_0000, 8'h04, 3}, 0, 3, 64'h1122_3344_5566_7788};
    tab[3]  = '{'{0, 0, 64'h8000_0008, 64'h0, 8'h00, 3}, 0, 3, 64'h1122_3344_55AB_7788};
    tab[4]  = '{'{0, 0, 64'h8000_0006, 64'h0, 8'h00, 2}, 1, 1, 64'h0};
    tab[5]  = '{'{0, 0, 64'h7FFF_FFF8, 64'h0, 8'h00, 3}, 1, 1, 64'h0};
    tab[6]  = '{'{0, 0, 64'h8008_0000, 64'h0, 8'h00, 3}, 1, 1, 64'h0};
    tab[7]  = '{'{0, 0, 64'h8007_FFF8, 64'h0, 8'h00, 3}, 0, 3, 64'h0};
    tab[8]  = '{'{0, 1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 3}, 0, 3, 64'h0};
    tab[9]  = '{'{0, 0, 64'h8000_0008, 64'h0, 8'h00, 3}, 0, 3, 64'h1122_3344_55AB_7788};
    tab[10] = '{'{0, 0, 64'h8000_0000, 64'h0, 8'h00, 4}, 1, 1, 64'h0};
    tab[11] = '{'{0, 0, 64'h8000_000B, 64'h0, 8'h00, 1}, 1, 1, 64'h0};
    tab[12] = '{'{0, 0, 64'h8000_000A, 64'h0, 8'h00, 1}, 0, 3, 64'h1122_3344_55AB_7788};
    tab[13] = '{'{1, 1, 64'h8000_0010, 64'hA5A5_A5A5_A5A5_A5A5, 8'hF0, 3}, 0, 6, 64'h0};
    tab[14] = '{'{1, 0, 64'h8000_0010, 64'h0, 8'h00, 3}, 0, 6, 64'hA5A5_A5A5_0000_0000};
    tab[15] = '{'{1, 0, 64'h8000_0004, 64'h0, 8'h00, 2}, 0, 6, 64'h0};
    tab[16] = '{'{0, 1, 64'h8000_0001, 64'h0000_0000_0000_EE00, 8'h02, 0}, 0, 3, 64'h1122_3344_55AB_7788};
    tab[17] = '{'{0, 0, 64'h8000_0000, 64'h0, 8'h00, 3}, 0, 3, 64'h0000_0000_0000_EE00};
    tab[18] = '{'{0, 1, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 3}, 1, 1, 64'h0};
    last_data[0] = '0;
    last_data[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dut0", {if0.ram_rw_ready, if0.ram_rw_err, en0, wen0, idx0} | {60'd0, if0.ram_rw_data[3:0]} | if0.ram_rw_data, 64'd0);
    chk("reset_dut0_sram", wd0 | bw0, 64'd0);
    chk("reset_dut1", {if1.ram_rw_ready, if1.ram_rw_err, en1, wen1, idx1} | if1.ram_rw_data | wd1 | bw1, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 19; i++) begin
      run(tab[i].r, tab[i].err, tab[i].lat, tab[i].data, 1'b0, tab[i].r);
      ref_apply(tab[i].r);
    end
    // back-to-back writes with cen held high between them
    r  = '{0, 1, 64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 8'hFF, 3};
    r2 = '{0, 1, 64'h8000_0018, 64'h89AB_CDEF_FEED_F00D, 8'hFF, 3};
    ref_expect(r, e, lat, d);
    run(r, e, lat, d, 1'b1, r2);
    ref_apply(r);
    ref_expect(r2, e, lat, d);
    run(r2, e, lat, d, 1'b0, r2);
    ref_apply(r2);
    r  = '{0, 0, 64'h8000_0010, 64'h0, 8'h00, 3};
    run(r, 0, 3, 64'hDEAD_BEEF_0123_4567, 1'b0, r);
    ref_apply(r);
    r  = '{0, 0, 64'h8000_0018, 64'h0, 8'h00, 3};
    run(r, 0, 3, 64'h89AB_CDEF_FEED_F00D, 1'b0, r);
    ref_apply(r);
    // reset during WAIT aborts a LATENCY=3 write to idx 5
    r = '{1, 1, 64'h8000_0028, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 3};
    en_before = en_cnt1;
    drive(r);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {if1.ram_rw_ready, if1.ram_rw_err, en1, wen1, idx1} | if1.ram_rw_data | wd1 | bw1, 64'd0);
    cen = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (if1.ram_rw_ready || en1) seen++;
    end
    chk("abort_quiet", seen, 0);
    chk("abort_no_access", en_cnt1 - en_before, 0);
    chk("abort_mem", mem1[5], 64'd0);
    rst_n = 1'b1;
    last_data[0] = '0;
    last_data[1] = '0;
    @(posedge clk);
    #1;
    r = '{1, 0, 64'h8000_0028, 64'h0, 8'h00, 3};
    run(r, 0, 6, 64'h0, 1'b0, r);
    ref_apply(r);
    // randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      r.sel   = 1'($urandom_range(0, 1));
      r.wen   = 1'($urandom_range(0, 1));
      r.addr  = BASE + (64'($urandom_range(0, 15)) << 3) +
                ($urandom_range(0, 3) == 0 ? 64'($urandom_range(1, 7)) : 64'd0);
      if ($urandom_range(0, 9) == 0)
        r.addr = $urandom_range(0, 1) ? BASE - 64'($urandom_range(1, 64)) : BASE + SPAN + 64'($urandom_range(0, 64));
      r.wdata = {$urandom, $urandom};
      r.wmask = 8'($urandom);
      r.size  = 3'($urandom_range(0, 4));
      ref_expect(r, e, lat, d);
      run(r, e, lat, d, 1'b0, r);
      ref_apply(r);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
